dcache_flush_unit: RTL and testbench

//  Write-back D$ flush walker, directly downstream of the flush controller. Consumes the

---
 rtl/dcache_flush_unit_pkg.sv | 18 +
 rtl/dcache_flush_unit_dirty_way_sel.sv | 24 ++
 rtl/dcache_flush_unit.sv | 179 +++++++++++++++++
 tb/tb_dcache_flush_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_flush_unit_pkg.sv
// Shared geometry defaults and FSM encoding for the D$ flush walker.
package dcache_flush_unit_pkg;

    localparam int unsigned DCACHE_NUM_SETS     = 256;
    localparam int unsigned DCACHE_NUM_WAYS     = 8;
    localparam int unsigned DCACHE_TAG_WIDTH    = 44;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        RWAIT = 3'd2,
        WB    = 3'd3,
        INV   = 3'd4,
        DONE  = 3'd5
    } flush_fsm_e;

endpackage

// File: rtl/dcache_flush_unit_dirty_way_sel.sv
// Lowest-set-bit priority encoder over the pending (valid & dirty) way mask.
module dcache_flush_unit_dirty_way_sel
    import dcache_flush_unit_pkg::*;
#(
    parameter  int unsigned NUM_WAYS  = DCACHE_NUM_WAYS,
    localparam int unsigned WAY_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic [NUM_WAYS-1:0]  pending_i,
    output logic [WAY_WIDTH-1:0] way_o,
    output logic                 empty_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        way_o   = '0;
        empty_o = ~|pending_i;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                way_o = WAY_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/dcache_flush_unit.sv
// Write-back D$ flush walker: reads every set, writes back valid+dirty ways
// lowest-first, invalidates the set, and pulses flush_ack_o once at the end.
// Optional feature macro: DCACHE_FLUSH_STATS_EN adds wb_count_o, a saturating
// count of writebacks in the most recent flush.
//
//   state | meaning
//   IDLE  | waiting for flush_i (masked the cycle after an ack)
//   READ  | requesting a read of set idx
//   RWAIT | waiting for read data; latches pending = valid & dirty, tags
//   WB    | writing back the lowest pending way until wb_ack_i
//   INV   | requesting invalidate of set idx
//   DONE  | one-cycle flush_ack_o
module dcache_flush_unit
    import dcache_flush_unit_pkg::*;
#(
    parameter  int unsigned NUM_SETS     = DCACHE_NUM_SETS,
    parameter  int unsigned NUM_WAYS     = DCACHE_NUM_WAYS,
    parameter  int unsigned TAG_WIDTH    = DCACHE_TAG_WIDTH,
    parameter  int unsigned OFFSET_WIDTH = DCACHE_OFFSET_WIDTH,
    localparam int unsigned INDEX_WIDTH  = $clog2(NUM_SETS),
    localparam int unsigned PADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH,
    localparam int unsigned WAY_WIDTH    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    output logic                          flush_ack_o,
    output logic                          busy_o,
    output logic                          arr_req_o,
    input  logic                          arr_gnt_i,
    output logic                          arr_we_o,
    output logic [INDEX_WIDTH-1:0]        arr_idx_o,
    input  logic                          arr_rvalid_i,
    input  logic [NUM_WAYS-1:0]           arr_valid_i,
    input  logic [NUM_WAYS-1:0]           arr_dirty_i,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0] arr_tag_i,
    output logic                          wb_req_o,
    output logic [WAY_WIDTH-1:0]          wb_way_o,
    output logic [PADDR_WIDTH-1:0]        wb_addr_o,
    input  logic                          wb_ack_i
`ifdef DCACHE_FLUSH_STATS_EN
    ,
    output logic [31:0]                   wb_count_o
`endif
);

    flush_fsm_e                         state_q, state_d;
    logic [INDEX_WIDTH-1:0]             idx_q, idx_d;
    logic [NUM_WAYS-1:0]                pending_q, pending_d;
    logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] tags_q, tags_d;
    logic                               ack_q, ack_d;
    logic [WAY_WIDTH-1:0]               sel_way;
    logic                               sel_empty;

    dcache_flush_unit_dirty_way_sel #(
        .NUM_WAYS (NUM_WAYS)
    ) u_dirty_way_sel (
        .pending_i (pending_q),
        .way_o     (sel_way),
        .empty_o   (sel_empty)
    );

    // Next-state, walk bookkeeping and Moore outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pending_d   = pending_q;
        tags_d      = tags_q;
        arr_req_o   = 1'b0;
        arr_we_o    = 1'b0;
        wb_req_o    = 1'b0;
        flush_ack_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                // ack_q hides the request the controller still holds right after our ack.
                if (flush_i && !ack_q) begin
                    state_d = READ;
                    idx_d   = '0;
                end
            end
            READ: begin
                arr_req_o = 1'b1;
                if (arr_gnt_i) begin
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                if (arr_rvalid_i) begin
                    pending_d = arr_valid_i & arr_dirty_i;
                    tags_d    = arr_tag_i;
                    state_d   = (|pending_d) ? WB : INV;
                end
            end
            WB: begin
                wb_req_o = !sel_empty;
                if (sel_empty) begin
                    state_d = INV;
                end else if (wb_ack_i) begin
                    pending_d[sel_way] = 1'b0;
                    if (pending_d == '0) begin
                        state_d = INV;
                    end
                end
            end
            INV: begin
                arr_req_o = 1'b1;
                arr_we_o  = 1'b1;
                if (arr_gnt_i) begin
                    if (idx_q == INDEX_WIDTH'(NUM_SETS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + INDEX_WIDTH'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                flush_ack_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ack_d = flush_ack_o;
    end

    assign busy_o    = (state_q != IDLE);
    assign arr_idx_o = idx_q;
    assign wb_way_o  = wb_req_o ? sel_way : '0;
    assign wb_addr_o = wb_req_o ? {tags_q[sel_way], idx_q, {OFFSET_WIDTH{1'b0}}} : '0;

    // State and walk registers; reset aborts any walk in progress without an ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= '0;
            tags_q    <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            tags_q    <= tags_d;
            ack_q     <= ack_d;
        end
    end

`ifdef DCACHE_FLUSH_STATS_EN
    logic [31:0] wb_count_q, wb_count_d;

    // Cleared when a flush is accepted, counts writeback acks, saturates, holds after ack.
    always_comb begin
        wb_count_d = wb_count_q;
        if (state_q == IDLE && flush_i && !ack_q) begin
            wb_count_d = '0;
        end else if (state_q == WB && wb_ack_i && wb_count_q != 32'hFFFF_FFFF) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    // Writeback counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_count_q <= '0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count_o = wb_count_q;
`endif

    // Read data and writeback acks outside the state that consumes them are dropped; flag them.
    a_rvalid_in_rwait: assert property (@(posedge clk_i) disable iff (!rst_ni)
        arr_rvalid_i |-> (state_q == RWAIT));
    a_wback_in_wb: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wb_ack_i |-> (state_q == WB));

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Bench for dcache_flush_unit (4 sets, 2 ways). A memory model answers array
// reads, a writeback responder acks 2 cycles after each request, and a
// reference model derives the writeback order and latency from cache contents.
module tb_dcache_flush_unit;

    localparam int NS     = 4;
    localparam int NW     = 2;
    localparam int TW     = 44;
    localparam int OW     = 4;
    localparam int IW     = 2;
    localparam int PW     = TW + IW + OW;
    localparam int WW     = 1;
    localparam int WB_DLY = 2;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    logic arr_gnt_i = 1'b0;
    logic arr_rvalid_i = 1'b0;
    logic wb_ack_i = 1'b0;
    logic [NW-1:0]    arr_valid_i = '0;
    logic [NW-1:0]    arr_dirty_i = '0;
    logic [NW*TW-1:0] arr_tag_i = '0;
    logic             flush_ack_o, busy_o, arr_req_o, arr_we_o, wb_req_o;
    logic [IW-1:0]    arr_idx_o;
    logic [WW-1:0]    wb_way_o;
    logic [PW-1:0]    wb_addr_o;
`ifdef DCACHE_FLUSH_STATS_EN
    logic [31:0]      wb_count_o;
`endif

    dcache_flush_unit #(
        .NUM_SETS     (NS),
        .NUM_WAYS     (NW),
        .TAG_WIDTH    (TW),
        .OFFSET_WIDTH (OW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .flush_ack_o  (flush_ack_o),
        .busy_o       (busy_o),
        .arr_req_o    (arr_req_o),
        .arr_gnt_i    (arr_gnt_i),
        .arr_we_o     (arr_we_o),
        .arr_idx_o    (arr_idx_o),
        .arr_rvalid_i (arr_rvalid_i),
        .arr_valid_i  (arr_valid_i),
        .arr_dirty_i  (arr_dirty_i),
        .arr_tag_i    (arr_tag_i),
        .wb_req_o     (wb_req_o),
        .wb_way_o     (wb_way_o),
        .wb_addr_o    (wb_addr_o),
`ifdef DCACHE_FLUSH_STATS_EN
        .wb_count_o   (wb_count_o),
`endif
        .wb_ack_i     (wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Cache contents model and observation state.
    bit            mv [NS][NW];
    bit            md [NS][NW];
    logic [TW-1:0] mt [NS][NW];
    logic [WW-1:0] exp_way [$];
    logic [PW-1:0] exp_addr [$];
    int            inv_q [$];
    int            tests = 0;
    int            fails = 0;
    int            reads = 0;
    int            wb_cycles = 0;
    int            stall_set = -1;
    int            stall_left = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Array / writeback responder and protocol monitor, one step per falling edge.
    initial begin : responder
        bit            rd_pend;
        int            rd_idx;
        int            age;
        bit            hold_v;
        bit            prev_stall;
        int            prev_idx;
        logic [WW-1:0] h_way;
        logic [PW-1:0] h_addr;
        rd_pend = 0; rd_idx = 0; age = 0; hold_v = 0; prev_stall = 0; prev_idx = 0;
        h_way = '0; h_addr = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                arr_gnt_i = 0; arr_rvalid_i = 0; wb_ack_i = 0;
                rd_pend = 0; age = 0; hold_v = 0; prev_stall = 0;
                continue;
            end
            arr_rvalid_i = rd_pend;
            if (rd_pend) begin
                for (int w = 0; w < NW; w++) begin
                    arr_valid_i[w] = mv[rd_idx][w];
                    arr_dirty_i[w] = md[rd_idx][w];
                    arr_tag_i[w*TW +: TW] = mt[rd_idx][w];
                end
            end else begin
                arr_valid_i = NW'($urandom());
                arr_dirty_i = NW'($urandom());
                arr_tag_i   = (NW*TW)'({$urandom(), $urandom(), $urandom()});
            end
            if (arr_req_o && !arr_we_o && int'(arr_idx_o) == stall_set && stall_left > 0) begin
                arr_gnt_i = 0;
                stall_left--;
            end else begin
                arr_gnt_i = arr_req_o;
            end
            if (prev_stall) begin
                chk("stall_req_held", arr_req_o, 1);
                chk("stall_idx_held", arr_idx_o, prev_idx);
            end
            prev_stall = arr_req_o && !arr_gnt_i;
            prev_idx   = int'(arr_idx_o);

            if (wb_req_o) age++; else age = 0;
            wb_ack_i = wb_req_o && (age == WB_DLY + 1);
            if (wb_ack_i) age = 0;

            if (wb_req_o) begin
                wb_cycles++;
                if (!hold_v) begin
                    h_way = wb_way_o; h_addr = wb_addr_o; hold_v = 1;
                end else begin
                    chk("wb_way_stable", wb_way_o, h_way);
                    chk("wb_addr_stable", wb_addr_o, h_addr);
                end
                if (wb_ack_i) begin
                    chk("wb_expected", exp_way.size() > 0, 1);
                    if (exp_way.size() > 0) begin
                        chk("wb_way", wb_way_o, exp_way.pop_front());
                        chk("wb_addr", wb_addr_o, exp_addr.pop_front());
                    end
                    hold_v = 0;
                end
            end else begin
                hold_v = 0;
            end

            rd_pend = arr_req_o && arr_gnt_i && !arr_we_o;
            if (rd_pend) begin
                reads++;
                rd_idx = int'(arr_idx_o);
            end
            if (arr_req_o && arr_gnt_i && arr_we_o) inv_q.push_back(int'(arr_idx_o));
        end
    end

    task automatic clear_cache();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                mv[s][w] = 0; md[s][w] = 0; mt[s][w] = TW'({$urandom(), $urandom()});
            end
    endtask

    task automatic random_cache();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                mv[s][w] = 1'($urandom_range(0, 1));
                md[s][w] = 1'($urandom_range(0, 1));
                mt[s][w] = TW'({$urandom(), $urandom()});
            end
    endtask

    // One complete flush; flush_i stays high through the ack and the masked cycle after it.
    task automatic run_flush(input string name, input int stall_s, input int stall_n);
        int n_dirty;
        int exp_lat;
        int lat;
        n_dirty = 0;
        exp_way.delete(); exp_addr.delete(); inv_q.delete();
        reads = 0; wb_cycles = 0;
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++)
                if (mv[s][w] && md[s][w]) begin
                    exp_way.push_back(WW'(w));
                    exp_addr.push_back({mt[s][w], IW'(s), 4'h0});
                    n_dirty++;
                end
        exp_lat = 3 * NS + 1 + n_dirty * (WB_DLY + 1) + stall_n;
        @(negedge clk_i);
        stall_set = stall_s; stall_left = stall_n;
        flush_i = 1;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!flush_ack_o && lat < 2000);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_in_done"}, busy_o, 1);
`ifdef DCACHE_FLUSH_STATS_EN
        chk({name, "_wb_count"}, wb_count_o, n_dirty);
`endif
        @(negedge clk_i);
        chk({name, "_ack_one_cycle"}, flush_ack_o, 0);
        chk({name, "_idle_after_ack"}, busy_o, 0);
        @(negedge clk_i);
        chk({name, "_no_second_walk"}, busy_o, 0);
        flush_i = 0;
        @(negedge clk_i);
        chk({name, "_still_idle"}, busy_o, 0);
        chk({name, "_no_extra_ack"}, flush_ack_o, 0);
`ifdef DCACHE_FLUSH_STATS_EN
        chk({name, "_wb_count_hold"}, wb_count_o, n_dirty);
`endif
        chk({name, "_reads"}, reads, NS);
        chk({name, "_inv_count"}, inv_q.size(), NS);
        for (int i = 0; i < inv_q.size(); i++) chk({name, "_inv_order"}, inv_q[i], i);
        chk({name, "_wb_missing"}, exp_way.size(), 0);
        chk({name, "_wb_cycles"}, wb_cycles, n_dirty * (WB_DLY + 1));
        stall_set = -1; stall_left = 0;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_ack"}, flush_ack_o, 0);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_arr_req"}, arr_req_o, 0);
        chk({name, "_arr_we"}, arr_we_o, 0);
        chk({name, "_arr_idx"}, arr_idx_o, 0);
        chk({name, "_wb_req"}, wb_req_o, 0);
        chk({name, "_wb_way"}, wb_way_o, 0);
        chk({name, "_wb_addr"}, wb_addr_o, 0);
`ifdef DCACHE_FLUSH_STATS_EN
        chk({name, "_wb_count"}, wb_count_o, 0);
`endif
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        clear_cache();
        @(negedge clk_i);
        chk_outputs_zero("reset");
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);

        // All clean, including dirty-but-invalid lines that must be skipped.
        clear_cache();
        md[1][0] = 1; md[3][1] = 1; mv[2][0] = 1;
        run_flush("clean", -1, 0);

        // Single dirty line in set 2, way 1.
        clear_cache();
        mv[2][1] = 1; md[2][1] = 1; mt[2][1] = TW'(44'hABC);
        run_flush("single", -1, 0);

        // Two dirty ways in set 0, written back without a bubble.
        clear_cache();
        mv[0][0] = 1; md[0][0] = 1; mv[0][1] = 1; md[0][1] = 1;
        run_flush("b2b", -1, 0);

        // Grant withheld for 5 cycles on the read of set 1.
        clear_cache();
        run_flush("stall", 1, 5);

        // Three dirty lines, then a clean flush clears the count.
        clear_cache();
        mv[0][1] = 1; md[0][1] = 1; mv[1][0] = 1; md[1][0] = 1; mv[3][1] = 1; md[3][1] = 1;
        run_flush("three", -1, 0);
        clear_cache();
        run_flush("clean2", -1, 0);

        // Randomised contents and grant stalls.
        for (int r = 0; r < 6; r++) begin
            random_cache();
            run_flush($sformatf("rand%0d", r), int'($urandom_range(0, NS - 1)),
                      int'($urandom_range(0, 4)));
        end

        // Reset asserted while a writeback of set 1 is in flight.
        clear_cache();
        mv[1][0] = 1; md[1][0] = 1; mv[1][1] = 1; md[1][1] = 1;
        @(negedge clk_i);
        flush_i = 1;
        n = 0;
        while (!wb_req_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk("rst_reached_wb", wb_req_o, 1);
        #2;
        rst_ni = 0;
        flush_i = 0;
        #1;
        chk_outputs_zero("async_rst");
        exp_way.delete(); exp_addr.delete(); inv_q.delete();
        repeat (3) @(negedge clk_i);
        chk_outputs_zero("held_rst");
        rst_ni = 1;
        @(negedge clk_i);
        chk("after_rst_idle", busy_o, 0);
        run_flush("post_rst", -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
